serial_tx: RTL and testbench
============================

# serial_tx

Parallel-in, serial-out transmitter that drives a single-bit serial stream into a downstream `d`/`q` flip-flop capture chain. A word is accepted through a valid/ready handshake and shifted out MSB first, one bit per `clock` cycle. A `frame` qualifier marks valid bits, and a one-cycle `done` pulse closes each word. This block is the sending end of the serial bit-capture path in the flip-flop design.

## Interface
- `WIDTH`, default 8: data word width in bits, minimum 2.
- `clock` input 1: single clock, rising-edge active.
- `reset` input 1: synchronous, active-high reset.
- `data_in` input WIDTH: word to transmit, sampled on handshake.
- `load_valid` input 1: upstream has a word on `data_in`.
- `load_ready` output 1: block can accept a word.
- `d` output 1: serial bit out, registered.
- `d_bar` output 1: complement of `d`, registered.
- `frame` output 1: high while `d` carries a data or parity bit.
- `done` output 1: one-cycle pulse after the last bit of a word.

## Operation
- States:
  - IDLE: `load_ready`=1, `frame`=0, `d`=0.
  - SHIFT: data bits are sent.
  - PARITY: exists only with the macro defined.
- Handshake:
  - A word is accepted on the rising edge where `load_valid` && `load_ready`.
  - `data_in` is copied into the shift register.
  - The bit counter is cleared and the state moves to SHIFT.
  - `load_valid` without `load_ready` is ignored; no queuing.
- SHIFT:
  - Each cycle, `d` = shift register MSB and the register shifts left by 1, filling with 0.
  - The counter increments from 0 to WIDTH-1; the counter width is $clog2(WIDTH).
  - After bit WIDTH-1, the next state is PARITY if compiled in, else IDLE.
- PARITY: `d` = XOR of all accepted data bits (even parity) for one cycle, then IDLE.
- `done` is high for exactly the first IDLE cycle after a frame; otherwise it is 0.
- `d_bar` is always the exact complement of `d`, including during reset.
- Reset:
  - Outputs while `reset` is high, and on the first cycle after its edge: `d`=0, `d_bar`=1, `frame`=0, `done`=0, `load_ready`=0.
  - When `reset` is released, the state is IDLE and `load_ready`=1 from the next cycle.
  - Reset mid-frame aborts the word with no `done` and no partial bits after the reset edge.
- A simultaneous `reset` and `load_valid` is ignored; reset wins.

## Timing
- Latency: the first data bit appears on `d` in the cycle after the accepting edge.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- `done` is asserted in the cycle after the last `frame`=1 cycle.
- `load_ready` is high in that same `done` cycle, so a back-to-back word can be accepted then. Minimum inter-frame gap is one cycle with `frame`=0.
- All outputs are registered; no combinational path from inputs to `d`, `d_bar`, `frame` or `done`.
- `load_ready` is decoded from the state register only.

## Configuration
- Macro: `SERIAL_TX_PARITY_EN`.
- Defined:
  - The PARITY state is present and one even-parity bit follows the data.
  - `frame` spans WIDTH+1 cycles.
- Undefined:
  - No PARITY state and no parity XOR logic.
  - `frame` spans WIDTH cycles and `done` follows bit WIDTH-1 directly.

## Structure
- Shared package `serial_pkg` holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the default WIDTH constant;
  - the counter-width function.
- One sub-module, `bit_counter`:
  - synchronous clear and enable;
  - a terminal-count output at WIDTH-1;
  - reused by the matching serial capture block.

## Test plan
- Reset held 3 cycles, then released → `d`=0, `d_bar`=1, `frame`=0, `done`=0 throughout; `load_ready`=1 one cycle after release.
- WIDTH=8, load 8'hA5, parity off → `d` = 1,0,1,0,0,1,0,1 over 8 `frame` cycles, then one `done` pulse.
- WIDTH=8, load 8'h07, parity on → 8 data bits, then a ninth bit `d`=1 with `frame`=1, then `done`.
- `load_valid` held high with words 8'hFF then 8'h00 → second word accepted in the `done` cycle; exactly one `frame`=0 cycle between frames.
- `load_valid` pulsed during SHIFT → ignored; the current word completes unchanged and `load_ready` stays 0.
- `reset` asserted after the 4th bit of 8'hC3 → `frame`=0 and `d`=0 from the next cycle, no `done`, and a fresh word transmits correctly afterwards.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and helpers for the serial bit-capture path:
//                transmitter state encoding, default word width and the
//                bit-counter width function.
//                Optional feature macro used by users of this package:
//                SERIAL_TX_PARITY_EN (even-parity bit after the data).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

   // Default data word width in bits (minimum 2).
   localparam int DEFAULT_WIDTH = 8;

   // ST_INIT holds the transmitter not-ready for the first cycle after reset.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_INIT   = 2'd3
   } state_e;

   // Width of a counter that indexes bits 0..w-1 of a word.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_counter
//  Description : Bit index counter for serial shift/capture blocks.
//                Synchronous clear has priority over enable; o_terminal flags
//                the last bit index (WIDTH-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int              c_CW   = cnt_width(WIDTH);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

   logic [c_CW-1:0] count_q;
   logic [c_CW-1:0] count_d;

   // Next count: clear wins, otherwise step when enabled.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable) begin
         count_d = count_q + c_CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_terminal = (count_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Parallel-in, serial-out transmitter. Accepts a word on a
//                valid/ready handshake and sends it MSB first on a registered
//                d/d_bar pair, with a frame qualifier and a one-cycle done
//                pulse after the last bit.
//                Macro SERIAL_TX_PARITY_EN: append one even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             d,
   output logic             d_bar,
   output logic             frame,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             d_q, d_d;
   logic             d_bar_q, d_bar_d;
   logic             frame_q, frame_d;
   logic             done_q, done_d;
   logic             cnt_clear, cnt_enable, cnt_last;
   logic             accept;
`ifdef SERIAL_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // Ready comes straight from the state register so upstream sees no
   // combinational dependency on its own valid.
   assign load_ready = (state_q == ST_IDLE);
   assign accept     = load_valid && load_ready;

   bit_counter #(
      .WIDTH      (WIDTH)
   ) u_bit_counter (
      .clk        (clock),
      .rst        (reset),
      .i_clear    (cnt_clear),
      .i_enable   (cnt_enable),
      .o_terminal (cnt_last)
   );

   // State register; reset parks in ST_INIT so ready stays low one more cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:  state_d = ST_IDLE;
         ST_IDLE:  if (load_valid) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt_last) begin
`ifdef SERIAL_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         ST_PARITY: state_d = ST_IDLE;
`endif
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output/datapath logic: computes what the output flops show next cycle.
   // The counter holds the index of the bit currently on d.
   always_comb begin
      d_d        = 1'b0;
      frame_d    = 1'b0;
      done_d     = 1'b0;
      shreg_d    = shreg_q;
      cnt_clear  = 1'b0;
      cnt_enable = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               d_d       = data_in[WIDTH-1];
               frame_d   = 1'b1;
               shreg_d   = {data_in[WIDTH-2:0], 1'b0};
               cnt_clear = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
               parity_d  = ^data_in;
`endif
            end
         end
         ST_SHIFT: begin
            if (cnt_last) begin
`ifdef SERIAL_TX_PARITY_EN
               d_d     = parity_q;
               frame_d = 1'b1;
`else
               done_d  = 1'b1;
`endif
            end else begin
               d_d        = shreg_q[WIDTH-1];
               frame_d    = 1'b1;
               shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_enable = 1'b1;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         ST_PARITY: done_d = 1'b1;
`endif
         default: ;
      endcase
      d_bar_d = ~d_d;
   end

   // Output and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         d_q      <= 1'b0;
         d_bar_q  <= 1'b1;
         frame_q  <= 1'b0;
         done_q   <= 1'b0;
         shreg_q  <= '0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         d_q      <= d_d;
         d_bar_q  <= d_bar_d;
         frame_q  <= frame_d;
         done_q   <= done_d;
         shreg_q  <= shreg_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign d     = d_q;
   assign d_bar = d_bar_q;
   assign frame = frame_q;
   assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Self-checking bench for serial_tx. Expected serial streams
//                come from a word-level model (bit i = word bit WIDTH-1-i,
//                optional parity = popcount parity).
//                Honours SERIAL_TX_PARITY_EN for the expected frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

   localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FLEN = W + 1;
`else
   localparam int FLEN = W;
`endif

   logic         clock = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] data_in;
   logic         load_ready;
   logic         d;
   logic         d_bar;
   logic         frame;
   logic         done;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   serial_tx #(
      .WIDTH      (W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .d          (d),
      .d_bar      (d_bar),
      .frame      (frame),
      .done       (done)
   );

   // Single comparison point.
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check every output in the current cycle.
   task automatic chk_out(input string tag, input logic e_d, input logic e_frame,
                          input logic e_done, input logic e_ready);
      logic e_db;
      e_db = ~e_d;
      chk({tag, ".d"},          {7'b0, d},          {7'b0, e_d});
      chk({tag, ".d_bar"},      {7'b0, d_bar},      {7'b0, e_db});
      chk({tag, ".frame"},      {7'b0, frame},      {7'b0, e_frame});
      chk({tag, ".done"},       {7'b0, done},       {7'b0, e_done});
      chk({tag, ".load_ready"}, {7'b0, load_ready}, {7'b0, e_ready});
   endtask

   // Word-level reference: i-th transmitted bit of a word.
   function automatic logic model_bit(input logic [W-1:0] word, input int i);
      if (i < W) return ((word >> (W - 1 - i)) & 1) != 0;
      return ($countones(word) % 2) == 1;
   endfunction

   // Called at the negedge after the accepting edge; checks bits 0..n-1 and
   // ends at the negedge of bit n-1. Optionally pulses load_valid mid-frame.
   task automatic check_bits(input logic [W-1:0] word, input int n, input bit pulse,
                             input string tag);
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clock);
         chk_out($sformatf("%s.bit%0d", tag, i), model_bit(word, i), 1'b1, 1'b0, 1'b0);
         if (pulse && i == 2) begin
            load_valid = 1'b1;
            data_in    = W'($urandom);
         end else if (pulse && i == 3) begin
            load_valid = 1'b0;
         end
      end
   endtask

   task automatic check_done(input string tag);
      @(negedge clock);
      chk_out(tag, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   // Present a word in an idle/done cycle and step past the accepting edge.
   task automatic start(input logic [W-1:0] word);
      data_in    = word;
      load_valid = 1'b1;
      @(negedge clock);
      load_valid = 1'b0;
   endtask

   logic [W-1:0] w;

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      data_in    = '0;

      // Reset held 3 cycles; a load attempt under reset must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk_out($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 1) begin
            load_valid = 1'b1;
            data_in    = 8'hFF;
         end
      end
      reset      = 1'b0;
      load_valid = 1'b0;
      @(negedge clock);
      chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

      // 8'hA5 then 8'h07.
      start(8'hA5);
      check_bits(8'hA5, FLEN, 1'b0, "a5");
      check_done("a5_done");
      @(negedge clock);
      chk_out("a5_after", 1'b0, 1'b0, 1'b0, 1'b1);

      start(8'h07);
      check_bits(8'h07, FLEN, 1'b0, "w07");
      check_done("w07_done");
      @(negedge clock);
      chk_out("w07_after", 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back with load_valid held high: FF then 00.
      data_in    = 8'hFF;
      load_valid = 1'b1;
      @(negedge clock);
      data_in    = 8'h00;
      check_bits(8'hFF, FLEN, 1'b0, "ff");
      check_done("ff_done");
      @(negedge clock);
      load_valid = 1'b0;
      check_bits(8'h00, FLEN, 1'b0, "zz");
      check_done("zz_done");
      @(negedge clock);
      chk_out("zz_after", 1'b0, 1'b0, 1'b0, 1'b1);

      // load_valid pulsed mid-frame must be ignored.
      w = W'($urandom);
      start(w);
      check_bits(w, FLEN, 1'b1, "pulse");
      check_done("pulse_done");

      // Reset after the 4th bit of 8'hC3 aborts the word.
      start(8'hC3);
      check_bits(8'hC3, 4, 1'b0, "c3");
      reset = 1'b1;
      @(negedge clock);
      chk_out("abort", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      chk_out("abort_rel", 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clock);
      chk_out("abort_idle", 1'b0, 1'b0, 1'b0, 1'b1);

      // Random words with random idle gaps (including back-to-back).
      for (int k = 0; k < 8; k++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         w   = W'($urandom);
         for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            chk_out($sformatf("rnd%0d.gap%0d", k, g), 1'b0, 1'b0, 1'b0, 1'b1);
         end
         start(w);
         check_bits(w, FLEN, (k % 2) == 1, $sformatf("rnd%0d", k));
         check_done($sformatf("rnd%0d_done", k));
      end
      @(negedge clock);
      chk_out("final_idle", 1'b0, 1'b0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
